// File: rtl/spi_master_xfer_if.sv
// spi_master_xfer_if: host request/response signals and SPI pins of spi_master_xfer.
// The master modport is the engine's view; slave is the host/slave-device side.
// rx_byte/rx_valid exist only when SPI_RX_STREAM_EN is defined.
interface spi_master_xfer_if;
   logic        start;
   logic        rw;
   logic [1:0]  addr;
   logic [2:0]  len;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        SS;
`ifdef SPI_RX_STREAM_EN
   logic [7:0]  rx_byte;
   logic        rx_valid;
`endif

   modport master (
      input  start, rw, addr, len, wdata, MISO,
      output rdata, busy, done, SCLK, MOSI, SS
`ifdef SPI_RX_STREAM_EN
      , output rx_byte, rx_valid
`endif
   );

   modport slave (
      output start, rw, addr, len, wdata, MISO,
      input  rdata, busy, done, SCLK, MOSI, SS
`ifdef SPI_RX_STREAM_EN
      , input rx_byte, rx_valid
`endif
   );
endinterface

// File: rtl/spi_master_xfer.sv
// spi_master_xfer: SPI mode-0 master that turns one host request into an
// SS-framed burst (address byte + 1..4 data bytes) for the 4x8 register slave.
// Optional macro SPI_RX_STREAM_EN adds a per-byte read stream (rx_byte/rx_valid).
module spi_master_xfer #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int SS_SETUP   = 4
) (
   input  logic              clk,
   input  logic              reset,
   spi_master_xfer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_LOW, S_HIGH, S_GAP, S_HOLD, S_DONE
   } state_t;

   localparam int            CW         = 16;
   localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(SS_SETUP - 1);

   state_t        state;
   logic [CW-1:0] cnt;        // cycles left in the current phase, minus one
   logic [2:0]    bit_cnt;    // 7 down to 0 within the current byte
   logic [2:0]    byte_cnt;   // 0 = address byte, 1..4 = data bytes
   logic [2:0]    nbytes;     // clamped data byte count
   logic          rw_q;
   logic [31:0]   wdata_q;    // write bytes, consumed from the low end
   logic [7:0]    tx_byte;    // current byte, MSB is the bit on MOSI
   logic [7:0]    rx_shift;

   logic [2:0]    len_clamped;
   logic [7:0]    rx_next;
   logic [1:0]    rx_idx;
   logic [7:0]    next_tx;

   // Request clamping, next rx byte and next tx byte.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      len_clamped = bus.len;
      if (bus.len == 3'd0)
         len_clamped = 3'd1;
      else if (bus.len > 3'd4)
         len_clamped = 3'd4;
      rx_next = {rx_shift[6:0], bus.MISO};
      rx_idx  = 2'(byte_cnt - 3'd1);
      next_tx = rw_q ? wdata_q[7:0] : 8'h00;
   end

   // Frame sequencer with registered SPI and host outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= 3'd7;
         byte_cnt <= 3'd0;
         nbytes   <= 3'd1;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         tx_byte  <= '0;
         rx_shift <= '0;
         // NOTE: rdata is a visible output register, so it is reset; the
         // shifters behind it need no particular value at reset.
         bus.rdata <= '0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.SCLK  <= 1'b0;
         bus.MOSI  <= 1'b0;
         bus.SS    <= 1'b1;
`ifdef SPI_RX_STREAM_EN
         bus.rx_byte  <= '0;
         bus.rx_valid <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
`ifdef SPI_RX_STREAM_EN
         bus.rx_valid <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  rw_q      <= bus.rw;
                  nbytes    <= len_clamped;
                  wdata_q   <= bus.wdata;
                  tx_byte   <= {bus.rw, 5'b00000, bus.addr};
                  bus.MOSI  <= bus.rw;
                  bus.SS    <= 1'b0;
                  bus.SCLK  <= 1'b0;
                  bus.busy  <= 1'b1;
                  bus.rdata <= '0;
                  bit_cnt   <= 3'd7;
                  byte_cnt  <= 3'd0;
                  cnt       <= SETUP_LOAD;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (cnt == '0) begin
                  cnt   <= DIV_LOAD;
                  state <= S_LOW;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_LOW: begin
               if (cnt == '0) begin
                  bus.SCLK <= 1'b1;
                  cnt      <= DIV_LOAD;
                  state    <= S_HIGH;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_HIGH: begin
               if (cnt == '0) begin
                  // Last HIGH cycle: sample MISO, drop SCLK, advance MOSI.
                  bus.SCLK <= 1'b0;
                  rx_shift <= rx_next;
                  if (bit_cnt != 3'd0) begin
                     bit_cnt  <= bit_cnt - 3'd1;
                     bus.MOSI <= tx_byte[6];
                     tx_byte  <= {tx_byte[6:0], 1'b0};
                     cnt      <= DIV_LOAD;
                     state    <= S_LOW;
                  end else begin
                     if (byte_cnt != 3'd0 && !rw_q) begin
                        bus.rdata[{rx_idx, 3'b000} +: 8] <= rx_next;
`ifdef SPI_RX_STREAM_EN
                        bus.rx_byte  <= rx_next;
                        bus.rx_valid <= 1'b1;
`endif
                     end
                     if (byte_cnt < nbytes) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        bit_cnt  <= 3'd7;
                        tx_byte  <= next_tx;
                        bus.MOSI <= next_tx[7];
                        wdata_q  <= {8'h00, wdata_q[31:8]};
                        cnt      <= GAP_LOAD;
                        state    <= S_GAP;
                     end else begin
                        bus.MOSI <= 1'b0;
                        cnt      <= SETUP_LOAD;
                        state    <= S_HOLD;
                     end
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_GAP: begin
               if (cnt == '0) begin
                  cnt   <= DIV_LOAD;
                  state <= S_LOW;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_HOLD: begin
               if (cnt == '0) begin
                  bus.SS   <= 1'b1;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb_spi_master_xfer: drives spi_master_xfer against a behavioural model of
// the 4x8 auto-incrementing register slave and checks bytes, data and timing.
module tb_spi_master_xfer;

   localparam int CLK_DIV    = 4;
   localparam int GAP_CYCLES = 8;
   localparam int SS_SETUP   = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   spi_master_xfer_if bus ();

   spi_master_xfer #(
      .CLK_DIV   (CLK_DIV),
      .GAP_CYCLES(GAP_CYCLES),
      .SS_SETUP  (SS_SETUP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Register slave: samples MOSI on SCLK rise, shifts MISO out on SCLK fall.
   logic [7:0] slv_regs [4] = '{default: 8'h00};
   logic [7:0] slv_rx;
   logic [7:0] slv_tx;
   logic [7:0] slv_next;
   logic [1:0] slv_ptr;
   logic       slv_wr;
   int         slv_nbits;
   int         slv_byte_idx;
   logic       slv_ss_prev;
   logic       slv_sclk_prev;
   logic [7:0] mosi_q [$];

   // Slave device reacting to SS and SCLK edges.
   always @(bus.SS or bus.SCLK) begin
      if (bus.SS !== slv_ss_prev) begin
         if (bus.SS === 1'b0) begin
            mosi_q.delete();
            slv_nbits    = 0;
            slv_byte_idx = 0;
            slv_tx       = 8'($urandom);
            bus.MISO     = slv_tx[7];
            slv_tx       = {slv_tx[6:0], 1'b0};
         end else begin
            bus.MISO = 1'b0;
         end
         slv_ss_prev = bus.SS;
      end
      if (bus.SCLK !== slv_sclk_prev) begin
         if (bus.SS === 1'b0 && bus.SCLK === 1'b1) begin
            slv_rx = {slv_rx[6:0], bus.MOSI};
            slv_nbits++;
            if (slv_nbits == 8) begin
               mosi_q.push_back(slv_rx);
               if (slv_byte_idx == 0) begin
                  slv_wr  = slv_rx[7];
                  slv_ptr = slv_rx[1:0];
               end else begin
                  if (slv_wr)
                     slv_regs[slv_ptr] = slv_rx;
                  slv_ptr = slv_ptr + 2'd1;
               end
               slv_next = slv_regs[slv_ptr];
               slv_byte_idx++;
               slv_nbits = 0;
            end
         end else if (bus.SS === 1'b0 && bus.SCLK === 1'b0) begin
            if (slv_nbits == 0)
               slv_tx = slv_next;
            bus.MISO = slv_tx[7];
            slv_tx   = {slv_tx[6:0], 1'b0};
         end
         slv_sclk_prev = bus.SCLK;
      end
   end

   // Reference view of the slave's registers.
   logic [7:0] ref_regs [4] = '{default: 8'h00};

   function automatic logic [31:0] pack_slave();
      return {slv_regs[3], slv_regs[2], slv_regs[1], slv_regs[0]};
   endfunction

   function automatic logic [31:0] pack_ref();
      return {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]};
   endfunction

   // inject: 0 = plain frame, 1 = extra start while busy, 2 = reset mid data byte 1
   task automatic run_frame(input logic rw, input logic [1:0] addr, input logic [2:0] len,
                            input logic [31:0] wdata, input int inject);
      int         n;
      int         exp_len;
      logic [7:0] exp_bytes [$];
      logic [31:0] exp_rdata;
      logic [7:0] rx_stream [$];
      int ss_low, busy_hi, rises, hi_run, low_run, hi_bad, low_bit, low_gap, low_other;
      int tail, mosi_bad;
      logic prev_sclk, mosi_at_rise, timed_out;

      n = (len == 3'd0) ? 1 : (len > 3'd4) ? 4 : int'(len);
      exp_len = 2 * SS_SETUP + (1 + n) * 16 * CLK_DIV + n * GAP_CYCLES;
      exp_bytes.push_back({rw, 5'b00000, addr});
      exp_rdata = '0;
      for (int i = 0; i < n; i++) begin
         exp_bytes.push_back(rw ? wdata[8*i +: 8] : 8'h00);
         if (!rw)
            exp_rdata[8*i +: 8] = ref_regs[2'(int'(addr) + i)];
      end

      @(negedge clk);
      bus.start = 1'b1;
      bus.rw    = rw;
      bus.addr  = addr;
      bus.len   = len;
      bus.wdata = wdata;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("rdata_cleared", bus.rdata, 32'd0);

      ss_low = 0; busy_hi = 0; rises = 0; hi_run = 0; low_run = 0; hi_bad = 0;
      low_bit = 0; low_gap = 0; low_other = 0; tail = 0; mosi_bad = 0;
      prev_sclk = 1'b0; mosi_at_rise = 1'b0; timed_out = 1'b1;

      for (int c = 0; c < 4000; c++) begin
         if (c > 0)
            @(negedge clk);
         if (inject == 1 && c == 100) begin
            bus.start = 1'b1;
            bus.rw    = ~rw;
            bus.addr  = addr + 2'd1;
            bus.len   = 3'd2;
            bus.wdata = ~wdata;
         end else if (inject == 1 && c == 101) begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            timed_out = 1'b0;
            check("busy_at_done", 32'(bus.busy), 32'd0);
            check("ss_at_done", 32'(bus.SS), 32'd1);
            break;
         end
`ifdef SPI_RX_STREAM_EN
         if (bus.rx_valid === 1'b1) begin
            rx_stream.push_back(bus.rx_byte);
            check("rx_byte_vs_rdata", 32'(bus.rx_byte),
                  32'(bus.rdata[8*(rx_stream.size()-1) +: 8]));
         end
`endif
         if (bus.SS === 1'b0)  ss_low++;
         if (bus.busy === 1'b1) busy_hi++;
         if (bus.SCLK === 1'b1) begin
            if (!prev_sclk) begin
               rises++;
               if (rises > 1) begin
                  if (low_run == CLK_DIV)                   low_bit++;
                  else if (low_run == CLK_DIV + GAP_CYCLES) low_gap++;
                  else                                      low_other++;
               end
               mosi_at_rise = bus.MOSI;
               hi_run = 0;
            end else if (bus.MOSI !== mosi_at_rise) begin
               mosi_bad++;
            end
            hi_run++;
         end else begin
            if (prev_sclk) begin
               if (hi_run != CLK_DIV) hi_bad++;
               low_run = 0;
               tail    = 0;
            end
            low_run++;
            if (bus.SS === 1'b0) tail++;
         end
         prev_sclk = bus.SCLK;

         if (inject == 2 && rises == 8 + 4 && bus.SCLK === 1'b1) begin
            reset = 1'b1;
            #1;
            check("abort_ss", 32'(bus.SS), 32'd1);
            check("abort_sclk", 32'(bus.SCLK), 32'd0);
            check("abort_busy", 32'(bus.busy), 32'd0);
            check("abort_rdata", bus.rdata, 32'd0);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check("abort_no_done", 32'(bus.done), 32'd0);
            end
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check("abort_idle_no_done", 32'(bus.done), 32'd0);
            end
            check("abort_regs", pack_slave(), pack_ref());
            return;
         end
      end

      check("done_seen", 32'(!timed_out), 32'd1);
      check("frame_len_ss", 32'(ss_low), 32'(exp_len));
      check("frame_len_busy", 32'(busy_hi), 32'(exp_len));
      check("sclk_rises", 32'(rises), 32'(8 * (1 + n)));
      check("sclk_high_width", 32'(hi_bad), 32'd0);
      check("sclk_low_bits", 32'(low_bit), 32'(7 * (1 + n)));
      check("sclk_low_gaps", 32'(low_gap), 32'(n));
      check("sclk_low_other", 32'(low_other), 32'd0);
      check("ss_hold_after_fall", 32'(tail), 32'(SS_SETUP));
      check("mosi_stable_high", 32'(mosi_bad), 32'd0);
      check("mosi_byte_count", 32'(mosi_q.size()), 32'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size() && i < mosi_q.size(); i++)
         check($sformatf("mosi_byte%0d", i), 32'(mosi_q[i]), 32'(exp_bytes[i]));
      check("rdata", bus.rdata, exp_rdata);
`ifdef SPI_RX_STREAM_EN
      check("rx_stream_count", 32'(rx_stream.size()), rw ? 32'd0 : 32'(n));
      for (int i = 0; i < rx_stream.size() && i < n; i++)
         check($sformatf("rx_stream%0d", i), 32'(rx_stream[i]), 32'(exp_rdata[8*i +: 8]));
`endif

      if (rw)
         for (int i = 0; i < n; i++)
            ref_regs[2'(int'(addr) + i)] = wdata[8*i +: 8];
      check("slave_regs", pack_slave(), pack_ref());

      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      check("rdata_held", bus.rdata, exp_rdata);
      check("ss_idle", 32'(bus.SS), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.rw    = 1'b0;
      bus.addr  = 2'd0;
      bus.len   = 3'd0;
      bus.wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_ss", 32'(bus.SS), 32'd1);
      check("reset_sclk", 32'(bus.SCLK), 32'd0);
      check("reset_mosi", 32'(bus.MOSI), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_rdata", bus.rdata, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_frame(1'b1, 2'd2, 3'd1, 32'h0000_00A5, 0);
      run_frame(1'b1, 2'd1, 3'd4, 32'h4433_2211, 0);
      run_frame(1'b0, 2'd3, 3'd2, 32'h0000_0000, 0);
      run_frame(1'b1, 2'd0, 3'd0, 32'hDEAD_BEEF, 1);
      run_frame(1'b0, 2'd0, 3'd7, 32'h0000_0000, 1);
      run_frame(1'b1, 2'd1, 3'd3, 32'h00C3_B2A1, 2);
      run_frame(1'b0, 2'd1, 3'd4, 32'h0000_0000, 0);

      for (int r = 0; r < 12; r++)
         run_frame(1'($urandom), 2'($urandom), 3'($urandom), $urandom, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
